// File: rtl/eeg_pea_eng_pe_mlane_if.sv
// Activation/weight input and packed output handshake bundle of the multi-lane PE.
// master = fetch/mux side, slave = PE side; all transfers are valid/ready.
interface eeg_pea_eng_pe_mlane_if #(
   parameter int LANE_NUM    = 4,
   parameter int DATA_ACT_DW = 8,
   parameter int DATA_WEI_DW = 8,
   parameter int DATA_OUT_DW = 8,
   parameter int ARAM_ADD_AW = 10,
   parameter int OMUX_ADD_AW = 8,
   parameter int CONV_WEI_DW = 3
);
   logic                            DIN_VLD;
   logic                            DIN_RDY;
   logic                            ACT_LST;
   logic                            WEI_LST;
   logic [DATA_ACT_DW-1:0]          ACT_DAT;
   logic [ARAM_ADD_AW-1:0]          ACT_ADD;
   logic [LANE_NUM*DATA_WEI_DW-1:0] WEI_DAT;
   logic [CONV_WEI_DW-1:0]          WEI_IDX;
   logic                            OUT_VLD;
   logic                            OUT_RDY;
   logic                            OUT_LST;
   logic [OMUX_ADD_AW-1:0]          OUT_ADD;
   logic [LANE_NUM*DATA_OUT_DW-1:0] OUT_DAT;

   modport master (
      output DIN_VLD, ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX, OUT_RDY,
      input  DIN_RDY, OUT_VLD, OUT_LST, OUT_ADD, OUT_DAT
   );
   modport slave (
      input  DIN_VLD, ACT_LST, WEI_LST, ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX, OUT_RDY,
      output DIN_RDY, OUT_VLD, OUT_LST, OUT_ADD, OUT_DAT
   );
endinterface

// File: rtl/eeg_pea_eng_pe_mlane.sv
// Multi-lane sparse conv PE: per-lane psum windows, requantised retire, 1-cycle output reg, stalls on !OUT_RDY.
// Optional ReLU before clipping when EEG_PE_RELU_EN is defined.
module eeg_pea_eng_pe_mlane #(
   parameter int LANE_NUM    = 4,
   parameter int DATA_ACT_DW = 8,
   parameter int DATA_WEI_DW = 8,
   parameter int DATA_OUT_DW = 8,
   parameter int DATA_SUM_DW = 24,
   parameter int DATA_SUM_NW = 8,
   parameter int ARAM_ADD_AW = 10,
   parameter int OMUX_ADD_AW = 8,
   parameter int CONV_WEI_DW = 3,
   parameter int CONV_RUN_DW = 3,
   parameter int CONV_MUL_DW = 24,
   parameter int CONV_SFT_DW = 8,
   parameter int CONV_ADD_DW = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   IS_IDLE,
   input  logic [CONV_RUN_DW-1:0] CFG_CONV_RUN,
   input  logic [CONV_WEI_DW-1:0] CFG_CONV_PAD,
   input  logic [CONV_MUL_DW-1:0] CFG_CONV_MUL,
   input  logic [CONV_SFT_DW-1:0] CFG_CONV_SFT,
   input  logic [CONV_ADD_DW-1:0] CFG_CONV_ADD,
   input  logic [OMUX_ADD_AW-1:0] CFG_CONV_LST,
   eeg_pea_eng_pe_mlane_if.slave  bus
);
   localparam int HW = ARAM_ADD_AW + CONV_WEI_DW + CONV_RUN_DW + 1;
   localparam int PW = DATA_SUM_DW + CONV_MUL_DW + 1;
   localparam int CW = CONV_WEI_DW + 1;
   localparam logic signed [PW-1:0] O_MAX = (PW'(1) <<< (DATA_OUT_DW-1)) - PW'(1);
   localparam logic signed [PW-1:0] O_MIN = -(PW'(1) <<< (DATA_OUT_DW-1));

   typedef enum logic [1:0] {S_IDLE, S_FLOW, S_PSUM} state_t;

   state_t                          state_q, state_d;
   logic [ARAM_ADD_AW-1:0]          head_q, head_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic signed [DATA_SUM_DW-1:0]   psum_q [LANE_NUM][DATA_SUM_NW];
   logic signed [DATA_SUM_DW-1:0]   psum_d [LANE_NUM][DATA_SUM_NW];
   logic signed [DATA_SUM_DW-1:0]   prod   [LANE_NUM];
   logic                            out_vld_q, out_vld_d;
   logic                            out_lst_q, out_lst_d;
   logic [OMUX_ADD_AW-1:0]          out_add_q, out_add_d;
   logic [LANE_NUM*DATA_OUT_DW-1:0] out_dat_q, out_dat_d;

   logic            st_idle, st_flow, st_psum;
   logic [HW-1:0]   win_end, win_nxt, act_ext;
   logic            out_free, ret_req, retire, din_rdy, din_hs, last_hs, flush_done;

   function automatic logic [DATA_OUT_DW-1:0] requant(input logic signed [DATA_SUM_DW-1:0] p);
      logic signed [PW-1:0] p_s, mul_s, add_s, full;
      p_s   = PW'(p);
      mul_s = PW'($signed(CFG_CONV_MUL));
      add_s = PW'($signed(CFG_CONV_ADD));
      full  = (p_s * mul_s + add_s) >>> CFG_CONV_SFT;
`ifdef EEG_PE_RELU_EN
      if (full[PW-1]) full = '0;
`endif
      if (full > O_MAX)      full = O_MAX;
      else if (full < O_MIN) full = O_MIN;
      return full[DATA_OUT_DW-1:0];
   endfunction

   assign st_idle  = (state_q == S_IDLE);
   assign st_flow  = (state_q == S_FLOW);
   assign st_psum  = (state_q == S_PSUM);
   // Window covers head .. head+PAD*RUN; one extra step is still acceptable input
   assign win_end  = HW'(head_q) + HW'(CFG_CONV_PAD) * HW'(CFG_CONV_RUN);
   assign win_nxt  = win_end + HW'(CFG_CONV_RUN);
   assign act_ext  = HW'(bus.ACT_ADD);

   assign out_free   = !out_vld_q | bus.OUT_RDY;
   assign ret_req    = (st_flow & bus.DIN_VLD & (act_ext > win_end)) |
                       (st_psum & (cnt_q <= CW'(CFG_CONV_PAD)));
   assign retire     = ret_req & out_free;
   assign din_hs     = bus.DIN_VLD & din_rdy;
   assign last_hs    = din_hs & bus.ACT_LST & bus.WEI_LST;
   assign flush_done = st_psum & (cnt_q == (CW'(CFG_CONV_PAD) + CW'(1))) & out_vld_q & bus.OUT_RDY;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (din_hs)     state_d = last_hs ? S_PSUM : S_FLOW;
         S_FLOW:  if (last_hs)    state_d = S_PSUM;
         S_PSUM:  if (flush_done) state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   always_comb begin
      IS_IDLE = st_idle;
      din_rdy = st_idle | (st_flow & !ret_req & (act_ext <= win_nxt));
   end

   always_comb begin
      for (int i = 0; i < LANE_NUM; i++) begin
         prod[i] = DATA_SUM_DW'($signed(bus.ACT_DAT)) *
                   DATA_SUM_DW'($signed(bus.WEI_DAT[i*DATA_WEI_DW +: DATA_WEI_DW]));
      end
   end

   always_comb begin
      head_d    = head_q;
      cnt_d     = cnt_q;
      psum_d    = psum_q;
      out_vld_d = out_vld_q;
      out_lst_d = out_lst_q;
      out_add_d = out_add_q;
      out_dat_d = out_dat_q;
      if (retire) begin
         out_vld_d = 1'b1;
         out_add_d = head_q[OMUX_ADD_AW-1:0];
         out_lst_d = (head_q[OMUX_ADD_AW-1:0] == CFG_CONV_LST);
         for (int i = 0; i < LANE_NUM; i++) begin
            out_dat_d[i*DATA_OUT_DW +: DATA_OUT_DW] = requant(psum_q[i][0]);
            for (int k = 0; k < DATA_SUM_NW-1; k++) psum_d[i][k] = psum_q[i][k+1];
            psum_d[i][DATA_SUM_NW-1] = '0;
         end
         head_d = head_q + ARAM_ADD_AW'(CFG_CONV_RUN);
         if (st_psum) cnt_d = cnt_q + CW'(1);
      end else if (bus.OUT_RDY) begin
         out_vld_d = 1'b0;
      end
      // Accept and retire are mutually exclusive, so psum_q is the right base here
      if (din_hs) begin
         if (st_idle) head_d = bus.ACT_ADD;
         for (int i = 0; i < LANE_NUM; i++) begin
            psum_d[i][bus.WEI_IDX] = psum_q[i][bus.WEI_IDX] + prod[i];
         end
      end
      if (flush_done) begin
         head_d = '0;
         cnt_d  = '0;
         psum_d = '{default: '0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q    <= '0;
         cnt_q     <= '0;
         psum_q    <= '{default: '0};
         out_vld_q <= 1'b0;
         out_lst_q <= 1'b0;
         out_add_q <= '0;
         out_dat_q <= '0;
      end else begin
         head_q    <= head_d;
         cnt_q     <= cnt_d;
         psum_q    <= psum_d;
         out_vld_q <= out_vld_d;
         out_lst_q <= out_lst_d;
         out_add_q <= out_add_d;
         out_dat_q <= out_dat_d;
      end
   end

   assign bus.DIN_RDY = din_rdy;
   assign bus.OUT_VLD = out_vld_q;
   assign bus.OUT_LST = out_lst_q;
   assign bus.OUT_ADD = out_add_q;
   assign bus.OUT_DAT = out_dat_q;
endmodule

// File: tb/tb_eeg_pea_eng_pe_mlane.sv
// Scoreboard bench for the multi-lane PE: a position-indexed conv model predicts every output beat.
module tb_eeg_pea_eng_pe_mlane;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        is_idle;
   logic [2:0]  cfg_run, cfg_pad;
   logic [23:0] cfg_mul, cfg_add;
   logic [7:0]  cfg_sft, cfg_lst;

   eeg_pea_eng_pe_mlane_if bus ();

   eeg_pea_eng_pe_mlane dut (
      .clk(clk), .rst(rst), .IS_IDLE(is_idle),
      .CFG_CONV_RUN(cfg_run), .CFG_CONV_PAD(cfg_pad), .CFG_CONV_MUL(cfg_mul),
      .CFG_CONV_SFT(cfg_sft), .CFG_CONV_ADD(cfg_add), .CFG_CONV_LST(cfg_lst),
      .bus(bus)
   );

   typedef struct packed { logic [9:0] add; logic [7:0] act; logic [31:0] wei; logic [2:0] idx; } item_t;
   typedef struct packed { logic [7:0] add; logic lst; logic [31:0] dat; } exp_t;

   item_t  frame_q[$];
   exp_t   exp_q[$];
   int     checks = 0;
   int     errors = 0;
   int     rdy_mode = 0;
   longint sums [0:511][0:3];

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.OUT_RDY = 1'b1;
         1:       bus.OUT_RDY = 1'($urandom_range(0, 1));
         default: bus.OUT_RDY = 1'b0;
      endcase
   end

   // Monitor: pops one expected beat per accepted output and checks hold while stalled
   exp_t        mon_e;
   logic        prev_stall = 1'b0;
   logic [7:0]  p_add;
   logic        p_lst;
   logic [31:0] p_dat;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!(bus.OUT_VLD && bus.OUT_ADD == p_add && bus.OUT_LST == p_lst && bus.OUT_DAT == p_dat)) begin
               errors++;
               $display("FAIL out_hold: got vld=%0b add=%0d dat=%h, required vld=1 add=%0d dat=%h",
                        bus.OUT_VLD, bus.OUT_ADD, bus.OUT_DAT, p_add, p_dat);
            end
         end
         if (bus.OUT_VLD && bus.OUT_RDY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL out_extra: got add=%0d dat=%h, required no beat", bus.OUT_ADD, bus.OUT_DAT);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.OUT_ADD != mon_e.add || bus.OUT_LST != mon_e.lst || bus.OUT_DAT != mon_e.dat) begin
                  errors++;
                  $display("FAIL out_beat: got add=%0d lst=%0b dat=%h, required add=%0d lst=%0b dat=%h",
                           bus.OUT_ADD, bus.OUT_LST, bus.OUT_DAT, mon_e.add, mon_e.lst, mon_e.dat);
               end
            end
         end
         prev_stall = bus.OUT_VLD && !bus.OUT_RDY;
         p_add = bus.OUT_ADD;
         p_lst = bus.OUT_LST;
         p_dat = bus.OUT_DAT;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   function automatic logic [7:0] ref_rq(input longint s);
      longint v;
      v = s * longint'($signed(cfg_mul)) + longint'($signed(cfg_add));
      v = v >>> cfg_sft;
`ifdef EEG_PE_RELU_EN
      if (v < 0) v = 0;
`endif
      if (v > 127)       v = 127;
      else if (v < -128) v = -128;
      return v[7:0];
   endfunction

   // Output positions are head0, head0+RUN, ...; an input lands at the head it sees plus IDX*RUN,
   // where the head has advanced just far enough for its address to fit the look-ahead.
   task automatic model_frame();
      int head0, h, need, pos, nout, run, pad;
      logic signed [7:0]  a, w;
      logic signed [23:0] wrapped;
      exp_t e;
      run = int'(cfg_run);
      pad = int'(cfg_pad);
      for (int p = 0; p < 512; p++) for (int l = 0; l < 4; l++) sums[p][l] = 0;
      head0 = int'(frame_q[0].add);
      h = head0;
      foreach (frame_q[n]) begin
         need = int'(frame_q[n].add) - pad * run;
         if (need > h) h = h + ((need - h + run - 1) / run) * run;
         pos = h + int'(frame_q[n].idx) * run;
         a = frame_q[n].act;
         for (int l = 0; l < 4; l++) begin
            w = frame_q[n].wei[l*8 +: 8];
            sums[pos][l] += longint'(a) * longint'(w);
         end
      end
      nout = (h - head0) / run + pad + 1;
      for (int k = 0; k < nout; k++) begin
         pos = head0 + k * run;
         e.add = pos[7:0];
         e.lst = (e.add == cfg_lst);
         for (int l = 0; l < 4; l++) begin
            wrapped = sums[pos][l][23:0];
            e.dat[l*8 +: 8] = ref_rq(longint'(wrapped));
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_frame(input int gaps);
      bit got;
      @(posedge clk); #1;
      foreach (frame_q[n]) begin
         bus.ACT_ADD = frame_q[n].add;
         bus.ACT_DAT = frame_q[n].act;
         bus.WEI_DAT = frame_q[n].wei;
         bus.WEI_IDX = frame_q[n].idx;
         bus.ACT_LST = (n == frame_q.size() - 1);
         bus.WEI_LST = (n == frame_q.size() - 1);
         bus.DIN_VLD = 1'b1;
         got = 1'b0;
         for (int t = 0; t < 1000 && !got; t++) begin
            @(negedge clk);
            if (bus.DIN_RDY) got = 1'b1;
            else begin @(posedge clk); #1; end
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL din_accept: item %0d add=%0d got no DIN_RDY, required acceptance", n, frame_q[n].add);
         end
         @(posedge clk); #1;
         bus.DIN_VLD = 1'b0;
         if (gaps != 0) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
      bus.DIN_VLD = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit ok = 1'b0;
      for (int t = 0; t < 3000 && !ok; t++) begin
         @(negedge clk);
         if (is_idle && exp_q.size() == 0) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL drain_%s: got idle=%0b pending=%0d, required idle=1 pending=0", name, is_idle, exp_q.size());
         exp_q.delete();
      end
   endtask

   function automatic item_t mk(input int add, input int act, input logic [31:0] wei, input int idx);
      item_t it;
      it.add = 10'(add);
      it.act = 8'(act);
      it.wei = wei;
      it.idx = 3'(idx);
      return it;
   endfunction

   task automatic set_cfg(input int run, input int pad, input int mul, input int sft, input int add, input int lst);
      cfg_run = 3'(run); cfg_pad = 3'(pad); cfg_mul = 24'(mul);
      cfg_sft = 8'(sft); cfg_add = 24'(add); cfg_lst = 8'(lst);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

   initial begin
      int a, n;
      bit seen;
      bus.DIN_VLD = 1'b0; bus.ACT_LST = 1'b0; bus.WEI_LST = 1'b0;
      bus.ACT_DAT = '0; bus.ACT_ADD = '0; bus.WEI_DAT = '0; bus.WEI_IDX = '0;
      set_cfg(1, 1, 1, 0, 0, 5);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_idle",    64'(is_idle),     64'd1);
      chk("rst_out_vld", 64'(bus.OUT_VLD), 64'd0);
      chk("rst_out_lst", 64'(bus.OUT_LST), 64'd0);
      chk("rst_out_add", 64'(bus.OUT_ADD), 64'd0);
      chk("rst_out_dat", 64'(bus.OUT_DAT), 64'd0);
      chk("rst_din_rdy", 64'(bus.DIN_RDY), 64'd1);
      rst = 1'b0;

      // single activation, two flush beats
      frame_q = {mk(5, 3, {8'h00, 8'h00, 8'hFF, 8'h02}, 0)};
      model_frame(); drive_frame(0); wait_drain("single");

      // requant rounding and both clip rails
      set_cfg(1, 1, 3, 2, 4, 20);
      frame_q = {mk(20, 10, {8'h00, 8'h9C, 8'h64, 8'h0A}, 0)};
      model_frame(); drive_frame(0); wait_drain("requant_a");
      set_cfg(1, 1, 1, 0, 0, 0);
      model_frame(); drive_frame(0); wait_drain("requant_b");

      // output stalled mid-frame
      frame_q = {mk(30, 5, 32'h01020304, 0), mk(30, -7, 32'hF0E01020, 1), mk(31, 9, 32'h11223344, 0),
                 mk(32, 2, 32'h7F80017F, 1), mk(33, -3, 32'h05060708, 0), mk(35, 4, 32'hFFFEFDFC, 1),
                 mk(36, 6, 32'h0A0B0C0D, 0)};
      model_frame();
      fork
         drive_frame(0);
         begin
            repeat (3) @(negedge clk);
            rdy_mode = 2;
            repeat (5) @(negedge clk);
            rdy_mode = 0;
         end
      join
      wait_drain("stall");

      // address jump forces zero-sum retires
      frame_q = {mk(0, 1, 32'h01010101, 0), mk(10, 2, 32'h03030303, 0)};
      model_frame(); drive_frame(0); wait_drain("jump");

      // reset while a flush beat is stuck in the output register
      rdy_mode = 2;
      frame_q = {mk(7, 3, 32'h01020304, 0)};
      model_frame(); drive_frame(0);
      seen = 1'b0;
      for (int t = 0; t < 50 && !seen; t++) begin
         @(negedge clk);
         if (bus.OUT_VLD) seen = 1'b1;
      end
      chk("psum_out_vld", 64'(seen), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_out_vld", 64'(bus.OUT_VLD), 64'd0);
      chk("rst2_out_dat", 64'(bus.OUT_DAT), 64'd0);
      chk("rst2_idle",    64'(is_idle),     64'd1);
      rst = 1'b0;
      exp_q.delete();
      rdy_mode = 0;
      frame_q = {mk(5, 3, {8'h00, 8'h00, 8'hFF, 8'h02}, 0)};
      model_frame(); drive_frame(0); wait_drain("after_rst");

      // randomized sparse frames with random backpressure
      rdy_mode = 1;
      for (int f = 0; f < 30; f++) begin
         set_cfg($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(1, 40),
                 $urandom_range(0, 6), int'($urandom_range(0, 128)) - 64, $urandom_range(0, 150));
         frame_q.delete();
         a = $urandom_range(0, 60);
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            if (i > 0) a += ($urandom_range(0, 5) == 0) ? $urandom_range(5, 15) : $urandom_range(0, 3);
            frame_q.push_back(mk(a, int'($urandom_range(0, 255)), $urandom, $urandom_range(0, int'(cfg_pad))));
         end
         model_frame(); drive_frame(1); wait_drain("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
